// File: rtl/memtest_pkg.sv
// Shared types, March C- element table and background helper for memtest_bist.
package memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_CHECK,
        ST_DONE
    } state_t;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // rd: element reads first; wr: element writes after the (optional) read;
    // up: ascending address order; exp_inv / wr_inv: use ~B instead of B.
    typedef struct packed {
        logic rd;
        logic wr;
        logic up;
        logic exp_inv;
        logic wr_inv;
    } elem_op_t;

    // Indexed by element number; entries 6 and 7 are never reached.
    localparam elem_op_t ELEM_OPS [0:7] = '{
        '{rd: 1'b0, wr: 1'b1, up: 1'b1, exp_inv: 1'b0, wr_inv: 1'b0},  // M0: up, w B
        '{rd: 1'b1, wr: 1'b1, up: 1'b1, exp_inv: 1'b0, wr_inv: 1'b1},  // M1: up, r B, w ~B
        '{rd: 1'b1, wr: 1'b1, up: 1'b1, exp_inv: 1'b1, wr_inv: 1'b0},  // M2: up, r ~B, w B
        '{rd: 1'b1, wr: 1'b1, up: 1'b0, exp_inv: 1'b0, wr_inv: 1'b1},  // M3: down, r B, w ~B
        '{rd: 1'b1, wr: 1'b1, up: 1'b0, exp_inv: 1'b1, wr_inv: 1'b0},  // M4: down, r ~B, w B
        '{rd: 1'b1, wr: 1'b0, up: 1'b0, exp_inv: 1'b0, wr_inv: 1'b0},  // M5: down, r B
        '{rd: 1'b0, wr: 1'b0, up: 1'b1, exp_inv: 1'b0, wr_inv: 1'b0},
        '{rd: 1'b0, wr: 1'b0, up: 1'b1, exp_inv: 1'b0, wr_inv: 1'b0}
    };

    // Checkerboard base: bit i is i[0], i.e. ...1010b; callers truncate to word width.
    localparam logic [7:0] CHECKER_BASE = 8'hAA;

    // Data background for an address: solid zero or a checkerboard that flips on odd addresses.
    function automatic logic [7:0] background(input logic addr_lsb, input logic pattern,
                                              input logic invert);
        logic [7:0] b;
        b = pattern ? (CHECKER_BASE ^ {8{addr_lsb}}) : 8'h00;
        return invert ? ~b : b;
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down March address counter with load, step and terminal-count flag.
module march_addr_gen #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 load_up,
    input  logic                 step,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 up_q, up_d;

    // Load picks direction and start address; step moves one address in the loaded direction.
    always_comb begin
        addr_d = addr_q;
        up_d   = up_q;
        if (load) begin
            up_d   = load_up;
            addr_d = load_up ? '0 : ADDR_MAX;
        end else if (step) begin
            addr_d = up_q ? (addr_q + ADDR_BITS'(1)) : (addr_q - ADDR_BITS'(1));
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            up_q   <= 1'b1;
        end else begin
            addr_q <= addr_d;
            up_q   <= up_d;
        end
    end

    assign addr = addr_q;
    // Terminal count compares against the end address, so the counter never needs to wrap.
    assign last = up_q ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/memtest_bist.sv
// Memory test top: direct macro access in IDLE, March C- self-test engine otherwise.
module memtest_bist
    import memtest_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 4,
    parameter int ERR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pattern,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [2:0]           fail_elem,
    output logic [ERR_BITS-1:0]  err_count
);

    state_t               state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic                 pattern_q, pattern_d;
    logic                 fail_q, fail_d;
    logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]           fail_elem_q, fail_elem_d;
    logic [ERR_BITS-1:0]  err_count_q, err_count_d;

    logic                 ag_load, ag_load_up, ag_step, ag_last;
    logic [ADDR_BITS-1:0] ag_addr;
    logic [DATA_BITS-1:0] exp_word, wr_word;
    logic                 miscompare, elem_end;
    logic [2:0]           elem_next;

    march_addr_gen #(
        .ADDR_BITS(ADDR_BITS)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ag_load),
        .load_up(ag_load_up),
        .step   (ag_step),
        .addr   (ag_addr),
        .last   (ag_last)
    );

    assign exp_word = DATA_BITS'(background(ag_addr[0], pattern_q, ELEM_OPS[elem_q].exp_inv));
    assign wr_word  = DATA_BITS'(background(ag_addr[0], pattern_q, ELEM_OPS[elem_q].wr_inv));

    // Next-state, March sequencing and miscompare bookkeeping.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        pattern_d   = pattern_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        err_count_d = err_count_q;
        ag_load     = 1'b0;
        ag_load_up  = 1'b1;
        ag_step     = 1'b0;
        miscompare  = 1'b0;
        elem_end    = 1'b0;
        elem_next   = elem_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_WR;
                    elem_d      = M0;
                    pattern_d   = pattern;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    err_count_d = '0;
                    ag_load     = 1'b1;
                    ag_load_up  = 1'b1;
                end
            end
            ST_WR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ag_last) begin
                    elem_end = 1'b1;
                end else begin
                    ag_step = 1'b1;
                    state_d = ELEM_OPS[elem_q].rd ? ST_RD_ISSUE : ST_WR;
                end
            end
            ST_RD_ISSUE: begin
                state_d = abort ? ST_IDLE : ST_RD_CHECK;
            end
            ST_RD_CHECK: begin
                miscompare = (mem_rdata != exp_word);
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ELEM_OPS[elem_q].wr) begin
                    state_d = ST_WR;
                end else if (ag_last) begin
                    elem_end = 1'b1;
                end else begin
                    ag_step = 1'b1;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (elem_end) begin
            if (elem_q == M5) begin
                state_d = ST_DONE;
            end else begin
                elem_d     = elem_next;
                ag_load    = 1'b1;
                ag_load_up = ELEM_OPS[elem_next].up;
                state_d    = ELEM_OPS[elem_next].rd ? ST_RD_ISSUE : ST_WR;
            end
        end

        if (miscompare) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_BITS'(1);
            end
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = ag_addr;
                fail_elem_d = elem_q;
            end
        end
    end

    // Macro port mux: direct path in IDLE, engine drives it in every other state.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ag_addr;
        mem_wdata = wr_word;
        case (state_q)
            ST_IDLE: begin
                mem_we    = we;
                mem_addr  = addr;
                mem_wdata = wdata;
            end
            ST_WR: begin
                mem_we = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            pattern_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            pattern_q   <= pattern_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            err_count_q <= err_count_d;
        end
    end

    assign rdata     = mem_rdata;
    assign busy      = (state_q == ST_WR) || (state_q == ST_RD_ISSUE) || (state_q == ST_RD_CHECK);
    assign done      = (state_q == ST_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_memtest_bist.sv
// Scoreboard bench for memtest_bist driving a 16x4 synchronous-read memory model.
module tb_memtest_bist;

    localparam int ADDR_BITS = 4;
    localparam int DATA_BITS = 4;
    localparam int ERR_BITS  = 8;

    localparam int SEL_BUSY    = 0;
    localparam int SEL_DONE    = 1;
    localparam int SEL_FAIL    = 2;
    localparam int SEL_FADDR   = 3;
    localparam int SEL_FELEM   = 4;
    localparam int SEL_ERR     = 5;
    localparam int SEL_MWE     = 6;
    localparam int SEL_MADDR   = 7;
    localparam int SEL_MWDATA  = 8;
    localparam int SEL_RDATA   = 9;
    localparam int SEL_MEM0    = 10;
    localparam int SEL_MEM1    = 11;
    localparam int SEL_BUSYRUN = 12;
    localparam int SEL_WERUN   = 13;
    localparam int SEL_MEMZERO = 14;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start, abort, pattern, we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 busy, done, fail;
    logic [ADDR_BITS-1:0] fail_addr;
    logic [2:0]           fail_elem;
    logic [ERR_BITS-1:0]  err_count;

    always #5 clk = ~clk;

    memtest_bist #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .ERR_BITS (ERR_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem),
        .err_count(err_count)
    );

    // Memory model: synchronous write, one-cycle read, optional bit 2 of word 5 stuck at 1.
    logic [DATA_BITS-1:0] mem [0:15];
    logic [DATA_BITS-1:0] mem_rdata_q;
    logic                 stuck_en;
    int                   cyc = 0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata_q <= (stuck_en && mem_addr == 4'd5) ? (mem[mem_addr] | 4'b0100) : mem[mem_addr];
    end
    assign mem_rdata = mem_rdata_q;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t keep_q[$];
    int   done_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   busy_run     = 0;
    int   we_run       = 0;
    logic busy_prev    = 1'b0;

    function automatic logic [31:0] mem_is_zero();
        for (int i = 0; i < 16; i++) if (mem[i] != '0) return 32'd0;
        return 32'd1;
    endfunction

    function automatic logic [31:0] actual_of(input int sel);
        case (sel)
            SEL_BUSY:    return 32'(busy);
            SEL_DONE:    return 32'(done);
            SEL_FAIL:    return 32'(fail);
            SEL_FADDR:   return 32'(fail_addr);
            SEL_FELEM:   return 32'(fail_elem);
            SEL_ERR:     return 32'(err_count);
            SEL_MWE:     return 32'(mem_we);
            SEL_MADDR:   return 32'(mem_addr);
            SEL_MWDATA:  return 32'(mem_wdata);
            SEL_RDATA:   return 32'(rdata);
            SEL_MEM0:    return 32'(mem[0]);
            SEL_MEM1:    return 32'(mem[1]);
            SEL_BUSYRUN: return 32'(busy_run);
            SEL_WERUN:   return 32'(we_run);
            SEL_MEMZERO: return mem_is_zero();
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sched_check(input int due, input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.due  = due;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic p, input logic w,
                                 input logic [3:0] ad, input logic [3:0] wd);
        start   = s;
        abort   = a;
        pattern = p;
        we      = w;
        addr    = ad;
        wdata   = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    // Monitor: busy-run bookkeeping, done-pulse scoreboard and scheduled comparisons.
    initial begin
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) begin
                busy_run = 1;
                we_run   = mem_we ? 1 : 0;
            end else if (busy) begin
                busy_run++;
                if (mem_we) we_run++;
            end
            busy_prev = busy;

            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    checkOutput("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end else if (done_q.size() > 0 && done_q[0] < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL missing_done: no pulse by cycle %0d, required at cycle %0d",
                         cyc, done_q[0]);
                void'(done_q.pop_front());
            end

            keep_q = {};
            foreach (exp_q[i]) begin
                if (exp_q[i].due == cyc) checkOutput(exp_q[i].name, actual_of(exp_q[i].sel), exp_q[i].exp);
                else keep_q.push_back(exp_q[i]);
            end
            exp_q = keep_q;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required end well before", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        stuck_en = 1'b0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Reset values
        tick();
        tick();
        c0 = cyc;
        sched_check(c0, "rst_busy", SEL_BUSY, 0);
        sched_check(c0, "rst_done", SEL_DONE, 0);
        sched_check(c0, "rst_fail", SEL_FAIL, 0);
        sched_check(c0, "rst_err", SEL_ERR, 0);
        sched_check(c0, "rst_faddr", SEL_FADDR, 0);
        sched_check(c0, "rst_felem", SEL_FELEM, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fault-free solid run; we held high while busy must not add writes
        tick();
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'hF);
        sched_check(c0 + 1, "t1_busy_rise", SEL_BUSY, 1);
        sched_check(c0 + 241, "t1_busy_len", SEL_BUSYRUN, 240);
        sched_check(c0 + 241, "t1_writes", SEL_WERUN, 80);
        sched_check(c0 + 241, "t1_busy_low", SEL_BUSY, 0);
        sched_check(c0 + 241, "t1_fail", SEL_FAIL, 0);
        sched_check(c0 + 241, "t1_err", SEL_ERR, 0);
        sched_check(c0 + 242, "t1_mem_zero", SEL_MEMZERO, 1);
        done_q.push_back(c0 + 241);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'hF);
        tick_to(c0 + 241);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 245);

        // Stuck-at-1 on bit 2 of word 5
        stuck_en = 1'b1;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 33, "t2_err_before", SEL_ERR, 0);
        sched_check(c0 + 34, "t2_err_first", SEL_ERR, 1);
        sched_check(c0 + 34, "t2_fail_first", SEL_FAIL, 1);
        sched_check(c0 + 34, "t2_faddr_first", SEL_FADDR, 5);
        sched_check(c0 + 241, "t2_fail", SEL_FAIL, 1);
        sched_check(c0 + 241, "t2_faddr", SEL_FADDR, 5);
        sched_check(c0 + 241, "t2_felem", SEL_FELEM, 1);
        sched_check(c0 + 241, "t2_err", SEL_ERR, 3);
        done_q.push_back(c0 + 241);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 245);

        // Checkerboard background, fault-free
        stuck_en = 1'b0;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 2, "t3_m0_we", SEL_MWE, 1);
        sched_check(c0 + 2, "t3_m0_addr", SEL_MADDR, 1);
        sched_check(c0 + 2, "t3_m0_wdata", SEL_MWDATA, 4'h5);
        sched_check(c0 + 17, "t3_word0", SEL_MEM0, 4'hA);
        sched_check(c0 + 17, "t3_word1", SEL_MEM1, 4'h5);
        sched_check(c0 + 113, "t3_m3_first_addr", SEL_MADDR, 15);
        sched_check(c0 + 115, "t3_m3_we", SEL_MWE, 1);
        sched_check(c0 + 115, "t3_m3_wdata", SEL_MWDATA, 4'hA);
        sched_check(c0 + 116, "t3_m3_next_addr", SEL_MADDR, 14);
        sched_check(c0 + 241, "t3_fail", SEL_FAIL, 0);
        sched_check(c0 + 241, "t3_err", SEL_ERR, 0);
        sched_check(c0 + 242, "t3_final_word0", SEL_MEM0, 4'hA);
        sched_check(c0 + 242, "t3_final_word1", SEL_MEM1, 4'h5);
        done_q.push_back(c0 + 241);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 245);

        // Abort and start together in IDLE: abort wins
        c0 = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 1, "t4_abort_wins", SEL_BUSY, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();

        // Abort at cycle 50 with a fault already logged
        stuck_en = 1'b1;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 50, "t5_busy_at_abort", SEL_BUSY, 1);
        sched_check(c0 + 51, "t5_busy_after", SEL_BUSY, 0);
        sched_check(c0 + 51, "t5_err_kept", SEL_ERR, 1);
        sched_check(c0 + 51, "t5_fail_kept", SEL_FAIL, 1);
        sched_check(c0 + 55, "t5_err_still", SEL_ERR, 1);
        sched_check(c0 + 55, "t5_faddr_kept", SEL_FADDR, 5);
        sched_check(c0 + 55, "t5_felem_kept", SEL_FELEM, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 50);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 58);

        // Restart after abort clears status and runs to completion
        stuck_en = 1'b0;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 1, "t6_err_clear", SEL_ERR, 0);
        sched_check(c0 + 1, "t6_fail_clear", SEL_FAIL, 0);
        sched_check(c0 + 1, "t6_faddr_clear", SEL_FADDR, 0);
        sched_check(c0 + 1, "t6_felem_clear", SEL_FELEM, 0);
        sched_check(c0 + 241, "t6_busy_len", SEL_BUSYRUN, 240);
        sched_check(c0 + 241, "t6_fail", SEL_FAIL, 0);
        done_q.push_back(c0 + 241);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 245);

        // Direct path write then read
        c0 = cyc;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'hA);
        sched_check(c0, "t7_we", SEL_MWE, 1);
        sched_check(c0, "t7_addr", SEL_MADDR, 3);
        sched_check(c0, "t7_wdata", SEL_MWDATA, 4'hA);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'h0);
        sched_check(c0 + 1, "t7_we_low", SEL_MWE, 0);
        sched_check(c0 + 2, "t7_rdata", SEL_RDATA, 4'hA);
        tick_to(c0 + 4);

        // Asynchronous reset in the middle of M3
        stuck_en = 1'b1;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        sched_check(c0 + 149, "t8_busy_pre", SEL_BUSY, 1);
        sched_check(c0 + 149, "t8_err_pre", SEL_ERR, 2);
        sched_check(c0 + 149, "t8_felem_pre", SEL_FELEM, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick_to(c0 + 150);
        rst_n = 1'b0;
        sched_check(c0 + 150, "t8_busy_rst", SEL_BUSY, 0);
        sched_check(c0 + 150, "t8_fail_rst", SEL_FAIL, 0);
        sched_check(c0 + 150, "t8_err_rst", SEL_ERR, 0);
        sched_check(c0 + 150, "t8_faddr_rst", SEL_FADDR, 0);
        sched_check(c0 + 150, "t8_felem_rst", SEL_FELEM, 0);
        sched_check(c0 + 150, "t8_done_rst", SEL_DONE, 0);
        tick();
        tick();
        rst_n    = 1'b1;
        stuck_en = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'h6);
        sched_check(cyc, "t8_direct_we", SEL_MWE, 1);
        sched_check(cyc, "t8_direct_addr", SEL_MADDR, 9);
        sched_check(cyc, "t8_direct_wdata", SEL_MWDATA, 4'h6);
        sched_check(cyc, "t8_idle_busy", SEL_BUSY, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        tick();

        // Anything still queued was never reached
        foreach (exp_q[i]) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: not checked, required at cycle %0d", exp_q[i].name, exp_q[i].due);
        end
        foreach (done_q[i]) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL pending_done: no pulse seen, required at cycle %0d", done_q[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
